// File: rtl/vecmac_pkg.sv
// Shared types and helpers for the vector MAC operand path.
// Holds the feeder FSM state encoding, the legal lane counts and ceil_div.
package vecmac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } feed_state_e;

   localparam int LANES_ONE  = 1;
   localparam int LANES_FOUR = 4;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/vec_tail_mask.sv
// Byte-enable for one output beat: a lane is live only if it is within the
// beat's lane count and its element index lies below ELEMS.
module vec_tail_mask
   import vecmac_pkg::*;
#(
   parameter int ELEMS = 1000
)(
   input  logic [31:0] base_idx,
   input  logic [2:0]  lanes,
   output logic [3:0]  byte_en
);

   always_comb begin
      byte_en = '0;
      for (int i = 0; i < 4; i++) begin
         if ((32'(i) < 32'(lanes)) && ((base_idx + 32'(i)) < 32'(ELEMS))) begin
            byte_en[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vec_operand_feeder.sv
// Streams INT8 operand vectors A and B from two word-wide memories to the MAC
// core, either one packed word per beat or one element per beat.
module vec_operand_feeder
   import vecmac_pkg::*;
#(
   parameter int ELEMS        = 1000,
   parameter int ACTIVE_LANES = 1,
   parameter int ADDR_W       = 10
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_a_rdata,
   input  logic [31:0]       mem_b_rdata,
   output logic              vec_valid,
   output logic [31:0]       vec_a,
   output logic [31:0]       vec_b,
   output logic              busy,
   output logic              done
);

   localparam int WORDS  = ceil_div(ELEMS, 4);
   localparam int BEATS  = ceil_div(ELEMS, ACTIVE_LANES);
   localparam int BEAT_W = $clog2(BEATS + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [BEAT_W-1:0] ALL_BEATS = BEAT_W'(BEATS);
   localparam bit WIDE = (ACTIVE_LANES == LANES_FOUR);

   if (ACTIVE_LANES != LANES_ONE && ACTIVE_LANES != LANES_FOUR) begin : g_bad_lanes
      $error("vec_operand_feeder: ACTIVE_LANES must be 1 or 4");
   end
   if (ELEMS < 1 || ELEMS > 4 * (2 ** ADDR_W)) begin : g_bad_elems
      $error("vec_operand_feeder: ELEMS out of range for ADDR_W");
   end

   feed_state_e       state_q, state_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        phase_q, phase_d;
   logic              rvld_q, rvld_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       buf_a_q, buf_a_d, buf_b_q, buf_b_d;
   logic              vld_q, vld_d, last_q, last_d, done_q, done_d;
   logic [31:0]       vec_a_q, vec_a_d, vec_b_q, vec_b_d;

   logic              emit;
   logic [31:0]       src_a, src_b;
   logic [1:0]        src_lane;
   logic [31:0]       base_idx;
   logic [3:0]        byte_en;
   logic [31:0]       lane_mask;

   assign base_idx  = WIDE ? (32'(beat_q) << 2) : 32'(beat_q);
   assign lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

   vec_tail_mask #(.ELEMS(ELEMS)) u_tail_mask (
      .base_idx (base_idx),
      .lanes    (3'(ACTIVE_LANES)),
      .byte_en  (byte_en)
   );

   always_comb begin
      state_d  = state_q;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      phase_d  = phase_q;
      rvld_d   = rd_en_q;
      beat_d   = beat_q;
      lane_d   = lane_q;
      buf_a_d  = buf_a_q;
      buf_b_d  = buf_b_q;
      vld_d    = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;
      vec_a_d  = '0;
      vec_b_d  = '0;
      emit     = 1'b0;
      src_a    = mem_a_rdata;
      src_b    = mem_b_rdata;
      src_lane = 2'd0;

      // Single-lane mode drains the buffered word between reads; fresh read
      // data always starts at lane 0 and refills the buffer.
      if (WIDE) begin
         emit = rvld_q && (beat_q != ALL_BEATS);
      end else begin
         emit = (rvld_q || (lane_q != 2'd0)) && (beat_q != ALL_BEATS);
         if (!rvld_q) begin
            src_a    = buf_a_q;
            src_b    = buf_b_q;
            src_lane = lane_q;
         end
      end

      if (emit) begin
         vld_d  = 1'b1;
         last_d = (beat_q == LAST_BEAT);
         beat_d = beat_q + BEAT_W'(1);
         if (WIDE) begin
            vec_a_d = src_a & lane_mask;
            vec_b_d = src_b & lane_mask;
         end else begin
            vec_a_d = {24'd0, src_a[{src_lane, 3'b000} +: 8]} & lane_mask;
            vec_b_d = {24'd0, src_b[{src_lane, 3'b000} +: 8]} & lane_mask;
            lane_d  = src_lane + 2'd1;
         end
         if (rvld_q) begin
            buf_a_d = mem_a_rdata;
            buf_b_d = mem_b_rdata;
         end
      end

      // phase spaces single-lane reads four cycles apart so the next word
      // lands exactly as the buffer runs out.
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               rd_en_d = 1'b1;
               addr_d  = '0;
               phase_d = 2'd0;
            end
         end
         ST_RUN: begin
            phase_d = phase_q + 2'd1;
            if (rd_en_q && (addr_q == LAST_ADDR)) begin
               state_d = ST_DRAIN;
            end else if (WIDE || (phase_q == 2'd3)) begin
               rd_en_d = 1'b1;
               addr_d  = addr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            state_d = ST_DRAIN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (vld_q && last_q) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
         beat_d  = '0;
         lane_d  = 2'd0;
      end

      if (abort) begin
         state_d = ST_IDLE;
         rd_en_d = 1'b0;
         rvld_d  = 1'b0;
         vld_d   = 1'b0;
         last_d  = 1'b0;
         done_d  = 1'b0;
         vec_a_d = '0;
         vec_b_d = '0;
         beat_d  = '0;
         lane_d  = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         phase_q <= 2'd0;
         rvld_q  <= 1'b0;
         beat_q  <= '0;
         lane_q  <= 2'd0;
         buf_a_q <= '0;
         buf_b_q <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         vec_a_q <= '0;
         vec_b_q <= '0;
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         phase_q <= phase_d;
         rvld_q  <= rvld_d;
         beat_q  <= beat_d;
         lane_q  <= lane_d;
         buf_a_q <= buf_a_d;
         buf_b_q <= buf_b_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         done_q  <= done_d;
         vec_a_q <= vec_a_d;
         vec_b_q <= vec_b_d;
      end
   end

   assign mem_rd_en = rd_en_q;
   assign mem_addr  = addr_q;
   assign vec_valid = vld_q;
   assign vec_a     = vec_a_q;
   assign vec_b     = vec_b_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule
